// File: rtl/ctrl_pkg.sv
// Shared types and program start-address table for the run controller.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        FINISH
    } state_t;

    typedef logic [1:0] prog_id_t;

    localparam int START_PC_W = 10;

    localparam logic [START_PC_W-1:0] PROG1_PC_DEF = 10'd0;
    localparam logic [START_PC_W-1:0] PROG2_PC_DEF = 10'd128;
    localparam logic [START_PC_W-1:0] PROG3_PC_DEF = 10'd256;

    typedef struct packed {
        logic                  valid;
        logic [START_PC_W-1:0] pc;
    } prog_start_t;

    // Program id 0 is reserved as "no program"; it yields valid=0.
    function automatic prog_start_t prog_start_pc(
        input prog_id_t              id,
        input logic [START_PC_W-1:0] pc1,
        input logic [START_PC_W-1:0] pc2,
        input logic [START_PC_W-1:0] pc3
    );
        prog_start_t r;
        r.valid = 1'b1;
        r.pc    = '0;
        case (id)
            2'd1:    r.pc = pc1;
            2'd2:    r.pc = pc2;
            2'd3:    r.pc = pc3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-value compare.
module sat_counter #(
    parameter int             W    = 16,
    parameter logic [W-1:0]   TERM = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == TERM);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: takes a start request, loads the program's start PC,
// releases the core, then waits for halt or the watchdog.
module prog_sequencer
    import ctrl_pkg::*;
#(
    parameter int                PC_W       = START_PC_W,
    parameter int                CYC_W      = 16,
    parameter logic [CYC_W-1:0]  MAX_CYCLES = '1,
    parameter logic [PC_W-1:0]   PROG1_PC   = PC_W'(PROG1_PC_DEF),
    parameter logic [PC_W-1:0]   PROG2_PC   = PC_W'(PROG2_PC_DEF),
    parameter logic [PC_W-1:0]   PROG3_PC   = PC_W'(PROG3_PC_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [1:0]       prog_sel,
    input  logic             halt,
    output logic             core_rst,
    output logic             pc_load,
    output logic [PC_W-1:0]  start_pc,
    output logic             run_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             err,
    output logic [CYC_W-1:0] cycles
);

    state_t            state_q,    state_d;
    logic [PC_W-1:0]   start_pc_q, start_pc_d;
    logic              done_q,     done_d;
    logic              timeout_q,  timeout_d;
    logic              err_q,      err_d;
    logic              cnt_clr;
    logic              cnt_en;
    logic              wdog_hit;
    prog_start_t       sel;

    // Terminal value is one below the limit: the compare is seen during the
    // last allowed RUN cycle, while that cycle's increment is still pending.
    sat_counter #(
        .W    (CYC_W),
        .TERM (MAX_CYCLES - CYC_W'(1))
    ) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cycles),
        .term_o  (wdog_hit)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        start_pc_d = start_pc_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        err_d      = err_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        sel        = prog_start_pc(prog_sel, START_PC_W'(PROG1_PC),
                                   START_PC_W'(PROG2_PC), START_PC_W'(PROG3_PC));

        case (state_q)
            IDLE, FINISH: begin
                if (req) begin
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    err_d     = 1'b0;
                    if (sel.valid) begin
                        start_pc_d = PC_W'(sel.pc);
                        cnt_clr    = 1'b1;
                        state_d    = INIT;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            INIT: state_d = RUN;
            RUN: begin
                cnt_en = 1'b1;
                if (halt) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = FINISH;
                end else if (wdog_hit) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            start_pc_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_pc_q <= start_pc_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
        end
    end

    // A rejected request never releases the core, so an error finish keeps it in reset.
    assign core_rst = (state_q == IDLE) || (state_q == INIT) ||
                      ((state_q == FINISH) && err_q);
    assign pc_load  = (state_q == INIT);
    assign run_en   = (state_q == RUN);
    assign busy     = (state_q == INIT) || (state_q == RUN);
    assign start_pc = start_pc_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench: a cycle-level behavioural model plus directed literal checks.
module tb_prog_sequencer;

    localparam int              PC_W  = 10;
    localparam int              CYC_W = 16;
    localparam logic [CYC_W-1:0] MAX  = 16'd20;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req = 1'b0;
    logic [1:0]       prog_sel = 2'd0;
    logic             halt = 1'b0;
    logic             core_rst;
    logic             pc_load;
    logic [PC_W-1:0]  start_pc;
    logic             run_en;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             err;
    logic [CYC_W-1:0] cycles;

    int checks   = 0;
    int failures = 0;

    prog_sequencer #(
        .PC_W       (PC_W),
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .prog_sel (prog_sel),
        .halt     (halt),
        .core_rst (core_rst),
        .pc_load  (pc_load),
        .start_pc (start_pc),
        .run_en   (run_en),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .err      (err),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PC_W-1:0] prog_addr(input logic [1:0] s);
        case (s)
            2'd2:    return 10'd128;
            2'd3:    return 10'd256;
            default: return 10'd0;
        endcase
    endfunction

    // Model: tracks what the run looks like after each edge.
    bit               m_valid = 1'b0;
    bit               m_init, m_run, m_hold, m_done, m_to, m_err;
    logic [PC_W-1:0]  m_pc;
    logic [CYC_W-1:0] m_cyc;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_init = 0; m_run = 0; m_hold = 1;
            m_done = 0; m_to = 0; m_err = 0;
            m_pc = '0; m_cyc = '0;
        end else if (m_init) begin
            m_init = 0; m_run = 1; m_hold = 0;
        end else if (m_run) begin
            if (m_cyc != '1) m_cyc = m_cyc + 1;
            if (halt) begin
                m_run = 0; m_done = 1; m_to = 0;
            end else if (m_cyc == MAX) begin
                m_run = 0; m_done = 1; m_to = 1;
            end
        end else if (req) begin
            m_done = 0; m_to = 0; m_err = 0;
            m_hold = 1;
            if (prog_sel != 2'd0) begin
                m_pc = prog_addr(prog_sel);
                m_cyc = '0;
                m_init = 1;
            end else begin
                m_err = 1; m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("core_rst", 32'(core_rst), 32'(m_hold));
            check("pc_load",  32'(pc_load),  32'(m_init));
            check("run_en",   32'(run_en),   32'(m_run));
            check("busy",     32'(busy),     32'(m_init | m_run));
            check("done",     32'(done),     32'(m_done));
            check("timeout",  32'(timeout),  32'(m_to));
            check("err",      32'(err),      32'(m_err));
            check("start_pc", 32'(start_pc), 32'(m_pc));
            check("cycles",   32'(cycles),   32'(m_cyc));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Drive a one-cycle request; returns in the cycle right after the acceptance edge.
    task automatic issue(input logic [1:0] s);
        req = 1'b1;
        prog_sel = s;
        step();
        req = 1'b0;
    endtask

    initial begin
        // Reset state
        steps(2);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_run_en",   32'(run_en),   32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_cycles",   32'(cycles),   32'd0);
        reset = 1'b0;
        step();

        // Normal run, program 3, halt sampled at edge 10
        issue(2'd3);
        check("n_pc_load",  32'(pc_load),  32'd1);
        check("n_start_pc", 32'(start_pc), 32'd256);
        step();
        check("n_run_en_first", 32'(run_en),   32'd1);
        check("n_core_free",    32'(core_rst), 32'd0);
        steps(8);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("n_done",    32'(done),    32'd1);
        check("n_cycles",  32'(cycles),  32'd9);
        check("n_timeout", 32'(timeout), 32'd0);
        check("n_run_off", 32'(run_en),  32'd0);
        steps(3);
        check("n_hold_cycles", 32'(cycles), 32'd9);

        // Watchdog, program 1, halt never raised
        issue(2'd1);
        steps(20);
        check("w_not_yet", 32'(done),   32'd0);
        check("w_cyc19",   32'(cycles), 32'd19);
        step();
        check("w_done",    32'(done),    32'd1);
        check("w_timeout", 32'(timeout), 32'd1);
        check("w_cycles",  32'(cycles),  32'd20);
        check("w_run_off", 32'(run_en),  32'd0);
        steps(2);

        // Back-to-back from FINISH, program 2, halt on RUN cycle 20
        issue(2'd2);
        check("b_done_clr", 32'(done),     32'd0);
        check("b_to_clr",   32'(timeout),  32'd0);
        check("b_start_pc", 32'(start_pc), 32'd128);
        check("b_cyc_clr",  32'(cycles),   32'd0);
        steps(20);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("s_done",    32'(done),    32'd1);
        check("s_timeout", 32'(timeout), 32'd0);
        check("s_cycles",  32'(cycles),  32'd20);

        // Requests during RUN are ignored
        issue(2'd3);
        steps(3);
        req = 1'b1; prog_sel = 2'd2;
        step();
        prog_sel = 2'd0;
        step();
        req = 1'b0;
        check("i_start_pc", 32'(start_pc), 32'd256);
        check("i_busy",     32'(busy),     32'd1);
        check("i_err",      32'(err),      32'd0);
        steps(2);

        // Reset mid-run for two cycles
        reset = 1'b1;
        step();
        check("r_core_rst", 32'(core_rst), 32'd1);
        check("r_run_en",   32'(run_en),   32'd0);
        check("r_done",     32'(done),     32'd0);
        check("r_cycles",   32'(cycles),   32'd0);
        step();
        reset = 1'b0;
        step();

        // Invalid program id from IDLE
        issue(2'd0);
        check("e_err",      32'(err),      32'd1);
        check("e_done",     32'(done),     32'd1);
        check("e_pc_load",  32'(pc_load),  32'd0);
        check("e_core_rst", 32'(core_rst), 32'd1);
        steps(2);

        // Short run, then invalid id from FINISH
        issue(2'd1);
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("f_cycles", 32'(cycles), 32'd1);
        issue(2'd0);
        check("f_err",  32'(err),  32'd1);
        check("f_done", 32'(done), 32'd1);
        steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
